// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the sequential multiply/divide unit: default width,
// operation encodings and the controller state type.
package mul_div_unit_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_e;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One non-restoring division step: shift the partial remainder left by one,
// then add or subtract the divisor depending on the remainder's sign.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH+1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_ext;

  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    // |rem_i| stays below the divisor, so dropping its top bit keeps the sign.
    shifted = {rem_i[WIDTH:0], quo_i[WIDTH-1]};
    dvs_ext = {2'b00, dvs_i};
    if (rem_i[WIDTH+1]) rem_o = shifted + dvs_ext;
    else                rem_o = shifted - dvs_ext;
    quo_o = {quo_i[WIDTH-2:0], ~rem_o[WIDTH+1]};
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// One step per clock in CALC; the last CALC cycle applies sign correction.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low
);

  localparam int CW = $clog2(ITERS + 1);
  localparam int AW = WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(ITERS);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [AW-1:0]    hi_q, hi_d;      // Booth accumulator / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;      // multiplier / quotient under construction
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;        // multiplicand / divisor magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic [WIDTH-1:0] z_high_q, z_high_d;
  logic [WIDTH-1:0] z_low_q, z_low_d;

  logic [AW-1:0]    m_ext, booth_sum;
  logic [AW-1:0]    step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] y_mag, b_mag;
  logic [WIDTH-1:0] quo_fix, rem_mag, rem_fix;

  assign y_mag = y_in[WIDTH-1]   ? -y_in   : y_in;
  assign b_mag = bus_in[WIDTH-1] ? -bus_in : bus_in;

  assign m_ext = {{2{m_q[WIDTH-1]}}, m_q};
  always_comb begin
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = hi_q + m_ext;
      2'b10:   booth_sum = hi_q - m_ext;
      default: booth_sum = hi_q;
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (hi_q),
    .quo_i (lo_q),
    .dvs_i (m_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Final non-restoring correction, then quotient/remainder sign fix-up.
  assign rem_mag = hi_q[AW-1] ? hi_q[WIDTH-1:0] + m_q : hi_q[WIDTH-1:0];
  assign rem_fix = a_neg_q ? -rem_mag : rem_mag;
  assign quo_fix = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    qm1_d         = qm1_q;
    m_d           = m_q;
    dvd_d         = dvd_q;
    a_neg_d       = a_neg_q;
    b_neg_d       = b_neg_q;
    dbz_d         = dbz_q;
    div_by_zero_d = div_by_zero_q;
    z_high_d      = z_high_q;
    z_low_d       = z_low_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_CALC;
          cnt_d         = '0;
          op_d          = op;
          hi_d          = '0;
          qm1_d         = 1'b0;
          dvd_d         = y_in;
          a_neg_d       = y_in[WIDTH-1];
          b_neg_d       = bus_in[WIDTH-1];
          dbz_d         = (op == OP_DIV) && (bus_in == '0);
          div_by_zero_d = 1'b0;
          if (op == OP_MUL) begin
            lo_d = bus_in;
            m_d  = y_in;
          end else begin
            lo_d = y_mag;
            m_d  = b_mag;
          end
        end
      end
      S_CALC: begin
        if (cnt_q == LAST) begin
          state_d = S_FINISH;
          cnt_d   = '0;
          if (op_q == OP_MUL) begin
            z_high_d = hi_q[WIDTH-1:0];
            z_low_d  = lo_q;
          end else if (dbz_q) begin
            z_high_d      = dvd_q;
            z_low_d       = '1;
            div_by_zero_d = 1'b1;
          end else begin
            z_high_d = rem_fix;
            z_low_d  = quo_fix;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_q == OP_MUL) begin
            hi_d  = {booth_sum[AW-1], booth_sum[AW-1:1]};
            lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
            qm1_d = lo_q[0];
          end else begin
            hi_d = step_rem;
            lo_d = step_quo;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= OP_MUL;
      hi_q          <= '0;
      lo_q          <= '0;
      qm1_q         <= 1'b0;
      m_q           <= '0;
      dvd_q         <= '0;
      a_neg_q       <= 1'b0;
      b_neg_q       <= 1'b0;
      dbz_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      z_high_q      <= '0;
      z_low_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      qm1_q         <= qm1_d;
      m_q           <= m_d;
      dvd_q         <= dvd_d;
      a_neg_q       <= a_neg_d;
      b_neg_q       <= b_neg_d;
      dbz_q         <= dbz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
      z_high_q      <= z_high_d;
      z_low_q       <= z_low_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  assign z_high      = z_high_q;
  assign z_low       = z_low_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: products, quotients, divide by
// zero, overflow case, ignored restarts and clear abort.
module tb_mul_div_unit;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;
  localparam int BOUND   = LATENCY + 10;

  logic          clock;
  logic          clear;
  logic          start;
  logic          op;
  logic [W-1:0]  y_in;
  logic [W-1:0]  bus_in;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  z_high;
  logic [W-1:0]  z_low;

  int n_checks = 0;
  int n_errors = 0;

  mul_div_unit #(.WIDTH(W), .ITERS(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .y_in        (y_in),
    .bus_in      (bus_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .z_high      (z_high),
    .z_low       (z_low)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for done; returns edges since acceptance (0 on timeout).
  task automatic wait_done(input int already, output int lat);
    lat = 0;
    for (int k = already + 1; k <= BOUND; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Called #1 after an edge with the DUT idle.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e_hi,
                        input logic [W-1:0] e_lo, input logic e_dbz);
    int lat;
    op = o; y_in = a; bus_in = b; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_dbz_clr"}, 64'(div_by_zero), 64'd0);
    op = ~o; y_in = ~a; bus_in = 32'h5A5A_0001;
    wait_done(0, lat);
    check({tag, "_lat"}, 64'(lat), 64'(LATENCY));
    check({tag, "_hi"}, 64'(z_high), 64'(e_hi));
    check({tag, "_lo"}, 64'(z_low), 64'(e_lo));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(e_dbz));
    tick();
    check({tag, "_done_drop"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    int n_done;
    clear = 1'b1; start = 1'b0; op = 1'b0; y_in = '0; bus_in = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz",  64'(div_by_zero), 64'd0);
    check("rst_z",    {z_high, z_low}, 64'd0);
    clear = 1'b0;

    run_op("mul_7x-3",    1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("mul_max_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("mul_-1x-1",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op("div_-7/2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_min/-1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("div_25/0",    1'b1, 32'd25,        32'd0,         32'h0000_0019, 32'hFFFF_FFFF, 1'b1);
    run_op("div_100/-7",  1'b1, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0);
    run_op("div_-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0);

    // Restart attempt mid-operation with a new multiplier, then a start held
    // during the done cycle: neither may produce a second operation.
    op = 1'b0; y_in = 32'd6; bus_in = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    start = 1'b1; bus_in = 32'd99;
    tick();
    start = 1'b0;
    wait_done(10, lat);
    check("restart_lat", 64'(lat), 64'(LATENCY));
    check("restart_lo", 64'(z_low), 64'd42);
    check("restart_hi", 64'(z_high), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("finish_start_ignored", 64'(busy), 64'd0);
    n_done = 0;
    for (int k = 0; k < BOUND; k++) begin
      tick();
      if (done) n_done++;
    end
    check("restart_no_second_done", 64'(n_done), 64'd0);

    // Abort a division with clear at cycle 15.
    op = 1'b1; y_in = 32'd1000; bus_in = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_dbz",  64'(div_by_zero), 64'd0);
    check("clr_z",    {z_high, z_low}, 64'd0);
    n_done = 0;
    for (int k = 0; k < BOUND; k++) begin
      tick();
      if (done) n_done++;
    end
    check("clr_no_done", 64'(n_done), 64'd0);

    run_op("mul_5x5_after_clr", 1'b0, 32'd5, 32'd5, 32'h0000_0000, 32'h0000_0019, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width; result is 2*WIDTH bits, split into z_high/z_low.
REQ-002 Parameter ITERS, default WIDTH: compute iterations per operation.
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  1  0 = MUL (signed), 1 = DIV (signed).
REQ-007 y_in  input  WIDTH  operand A (multiplicand / dividend), from Y register.
REQ-008 bus_in  input  WIDTH  operand B (multiplier / divisor), from bus.
REQ-009 busy  output  1  high from the cycle after start is accepted until done drops.
REQ-010 done  output  1  one-cycle pulse; results valid.
REQ-011 div_by_zero  output  1  set with done when op=DIV and divisor=0.
REQ-012 z_high  output  WIDTH  product[2W-1:W] or remainder; feeds the bus mux zhigh input.
REQ-013 z_low  output  WIDTH  product[W-1:0] or quotient; feeds the bus mux zlow input.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and FINISH; IDLE->CALC on start, CALC->FINISH after ITERS cycles, FINISH->IDLE unconditionally.
REQ-015 On the edge where start=1 in IDLE, op, y_in and bus_in SHALL be latched; later operand changes have no effect.
REQ-016 The iteration counter SHALL run 0..ITERS-1 in CALC, one step per cycle, and hold at 0 in IDLE.
REQ-017 MUL SHALL use radix-2 Booth recoding on latched operands; result = exact signed 2W-bit product.
REQ-018 DIV SHALL use non-restoring division on operand magnitudes, then sign-correct: quotient truncates toward zero, remainder carries dividend's sign.
REQ-019 DIV by zero SHALL yield z_low = all ones, z_high = dividend, div_by_zero=1, with normal latency.
REQ-020 DIV of -2^(W-1) by -1 SHALL yield z_low = 0x80000000, z_high = 0, div_by_zero=0.
REQ-021 z_high/z_low SHALL update only on the CALC->FINISH edge and hold until the next FINISH.
REQ-022 done SHALL be 1 exactly during FINISH; start accepted at edge N gives done=1 in the cycle after edge N+ITERS+1 (33-cycle latency at WIDTH=32).
REQ-023 start while busy or in FINISH SHALL be ignored, with no queueing.
REQ-024 div_by_zero SHALL be valid only with done and cleared on the next start acceptance.
REQ-025 start and done in the same cycle SHALL be ignored; a new request needs IDLE.

Reset
REQ-026 clear=1 SHALL force IDLE, counter=0, busy=0, done=0, div_by_zero=0, z_high=0, z_low=0 at the next edge.
REQ-027 clear SHALL take priority over start and abort any in-flight operation without a done pulse.
REQ-028 Operation SHALL resume normally on the first edge after clear deasserts.

Structure
REQ-029 A shared datapath package SHALL hold WIDTH default, the op encodings (OP_MUL, OP_DIV) and the FSM state enum.
REQ-030 The single sub-module div_step SHALL be combinational and hold one non-restoring add/subtract-and-shift step; the Booth step stays inline.
REQ-031 There SHALL be no combinational path from inputs to any output.

Verification
REQ-032 MUL 7 x -3 -> after 33 cycles done=1, z_high=0xFFFFFFFF, z_low=0xFFFFFFEB.
REQ-033 MUL 0x80000000 x 0x80000000 -> z_high=0x40000000, z_low=0x00000000.
REQ-034 DIV -7 / 2 -> z_low=0xFFFFFFFD, z_high=0xFFFFFFFF; DIV 0x80000000 / -1 -> z_low=0x80000000, z_high=0.
REQ-035 DIV 25 / 0 -> div_by_zero=1, z_low=0xFFFFFFFF, z_high=0x00000019, done at cycle 33.
REQ-036 start pulsed again at cycle 10 of a MUL and bus_in changed -> single done at cycle 33 with the original result.
REQ-037 clear asserted at cycle 15 of a DIV -> no done, all outputs 0; a new MUL 5 x 5 afterwards gives z_low=25.
